spi_master_ctrl: RTL and testbench

- Bus master and sequencer for the team's SPI slave datapath.
- Accepts a burst command of 1..2^LEN_W bytes and drives ss/sck/mosi in mode 0 (sck idles low; mosi changes while sck is low; data sampled on the sck rising edge), LSB first.
- Streams TX bytes in and RX bytes out over valid/ready handshakes.
- Sits between the system-side command logic and the off-chip or on-chip SPI slave.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_tick_gen.sv | 26 ++
 rtl/spi_master_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master controller and its wait-timer.
package spi_pkg;

    localparam int SPI_BITS = 8;

    typedef logic [SPI_BITS-1:0] spi_byte_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOAD  = 3'd2,
        LOW   = 3'd3,
        HIGH  = 3'd4,
        HOLD  = 3'd5,
        GAP   = 3'd6
    } spi_state_e;

    // Largest of the four wait lengths; sizes the shared down-counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Down-counter reloaded with N-1 on restart; tick is high while the count sits at zero.
module spi_tick_gen #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         restart,
    input  logic [W-1:0] load_val,
    output logic         tick
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0, LSB-first SPI burst master: one command moves 1..2^LEN_W bytes under a single ss assertion.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = 25,
    parameter int SETUP_CYC   = 25,
    parameter int HOLD_CYC    = 25,
    parameter int GAP_CYC     = 25,
    parameter int LEN_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             sck,
    output logic             ss,
    output logic             mosi,
    input  logic             miso,
    output logic [2:0]       state_dbg
);

    // Handshakes: cmd is taken on a cycle with cmd_valid && cmd_ready, a tx byte on
    // tx_valid && tx_ready; rx_valid is a single-cycle pulse with no backpressure.

    localparam int CNT_W = $clog2(max4(HALF_PERIOD, SETUP_CYC, HOLD_CYC, GAP_CYC)) + 1;

    localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

    spi_state_e       state;
    logic [LEN_W-1:0] byte_cnt;
    logic [2:0]       bit_cnt;
    logic [2:0]       next_bit;
    spi_byte_t        tx_shift;
    logic [6:0]       rx_shift;

    logic             tick;
    logic             restart;
    logic [CNT_W-1:0] load_val;

    assign cmd_ready = (state == IDLE);
    assign tx_ready  = (state == LOAD);
    assign state_dbg = state;
    assign next_bit  = bit_cnt + 3'd1;

    // Reload the shared timer on the same edge as every transition into a timed state.
    always_comb begin
        restart  = 1'b0;
        load_val = '0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    restart  = 1'b1;
                    load_val = SETUP_LD;
                end
            end
            LOAD: begin
                if (tx_valid) begin
                    restart  = 1'b1;
                    load_val = HALF_LD;
                end
            end
            LOW: begin
                if (tick) begin
                    restart  = 1'b1;
                    load_val = HALF_LD;
                end
            end
            HIGH: begin
                if (tick) begin
                    restart  = 1'b1;
                    load_val = (bit_cnt == 3'd7 && byte_cnt == '0) ? HOLD_LD : HALF_LD;
                end
            end
            HOLD: begin
                if (tick) begin
                    restart  = 1'b1;
                    load_val = GAP_LD;
                end
            end
            default: begin
                restart  = 1'b0;
                load_val = '0;
            end
        endcase
    end

    spi_tick_gen #(
        .W (CNT_W)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .load_val (load_val),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            sck      <= 1'b0;
            ss       <= 1'b1;
            mosi     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        byte_cnt <= cmd_len;
                        busy     <= 1'b1;
                        ss       <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) state <= LOAD;
                end
                LOAD: begin
                    sck <= 1'b0;
                    if (tx_valid) begin
                        tx_shift <= tx_data;
                        mosi     <= tx_data[0];
                        bit_cnt  <= '0;
                        state    <= LOW;
                    end
                end
                LOW: begin
                    if (tick) begin
                        sck   <= 1'b1;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        sck <= 1'b0;
                        if (bit_cnt != 3'd7) begin
                            rx_shift[bit_cnt] <= miso;
                            bit_cnt           <= next_bit;
                            mosi              <= tx_shift[next_bit];
                            state             <= LOW;
                        end else begin
                            // Bit 7 goes straight into rx_data; the shift register holds bits 0..6.
                            rx_data  <= {miso, rx_shift};
                            rx_valid <= 1'b1;
                            if (byte_cnt != '0) begin
                                byte_cnt <= byte_cnt - 1'b1;
                                state    <= LOAD;
                            end else begin
                                state <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        ss    <= 1'b1;
                        done  <= 1'b1;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: bus-level monitor plus a slave model that echoes mosi or returns the previous byte.
module tb_spi_master_ctrl;

    localparam int HALF  = 4;
    localparam int SETUP = 2;
    localparam int HOLD  = 2;
    localparam int GAP   = 2;
    localparam int LEN_W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [7:0]       tx_data = '0;
    logic             tx_valid = 1'b0;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             busy;
    logic             done;
    logic             sck;
    logic             ss;
    logic             mosi;
    logic             miso;
    logic [2:0]       state_dbg;

    spi_master_ctrl #(
        .HALF_PERIOD (HALF),
        .SETUP_CYC   (SETUP),
        .HOLD_CYC    (HOLD),
        .GAP_CYC     (GAP),
        .LEN_W       (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .done      (done),
        .sck       (sck),
        .ss        (ss),
        .mosi      (mosi),
        .miso      (miso),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];      // expected rx bytes
    logic [7:0] exp_tx_q[$];   // expected bytes seen on mosi
    int         exp_len_q[$];  // expected byte count per burst
    logic [7:0] rx_log[$];
    logic [7:0] mosi_log[$];
    logic [7:0] burst_q[$];

    // slave model: loopback echoes mosi, otherwise returns the previously received byte
    logic       loop_mode = 1'b1;
    logic [7:0] cur_out = 8'h00;
    logic [2:0] fall_bit = 3'd0;
    logic [7:0] drv_prev = 8'h00;
    assign miso = loop_mode ? mosi : cur_out[fall_bit];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / compare process ----------------
    logic       sck_q, ss_q, first_rise;
    int         run, since_ss, since_fall, since_ss_rise, rise_bit;
    int         burst_rises = 0, total_rises = 0, done_cnt = 0;
    logic [7:0] mosi_acc, last_mosi_byte;

    always @(negedge clk) begin
        if (rst) begin
            sck_q = 1'b0; ss_q = 1'b1; first_rise = 1'b1;
            run = 1; since_ss = 0; since_fall = 0; since_ss_rise = 1000; rise_bit = 0;
            fall_bit = 3'd0; cur_out = 8'h00; last_mosi_byte = 8'h00; mosi_acc = 8'h00;
            burst_rises = 0;
        end else begin
            since_ss++; since_fall++; since_ss_rise++;
            chk("cmd_ready_eq_not_busy", cmd_ready, !busy);
            chk("done_iff_ss_rise", done, ss && !ss_q);
            if (ss) chk("sck_low_while_ss_high", sck, 1'b0);
            if (tx_ready) begin
                chk("load_sck_low", sck, 1'b0);
                chk("load_ss_low", ss, 1'b0);
            end
            if (!ss && ss_q) begin
                chk("ss_high_min_gap", since_ss_rise >= GAP, 1);
                since_ss = 0; first_rise = 1'b1; burst_rises = 0;
            end
            if (sck != sck_q) begin
                if (sck) begin
                    if (first_rise) chk("ss_fall_to_first_rise", since_ss >= SETUP + HALF, 1);
                    else if (rise_bit != 0) chk("sck_low_width", run, HALF);
                    else chk("sck_low_width_between_bytes", run >= HALF + 1, 1);
                    first_rise = 1'b0;
                    mosi_acc[rise_bit] = mosi;
                    rise_bit++; burst_rises++; total_rises++;
                    if (rise_bit == 8) begin
                        rise_bit = 0;
                        last_mosi_byte = mosi_acc;
                        mosi_log.push_back(mosi_acc);
                        chk("mosi_byte_pending", exp_tx_q.size() > 0, 1);
                        if (exp_tx_q.size() > 0) chk("mosi_byte", mosi_acc, exp_tx_q.pop_front());
                    end
                end else begin
                    chk("sck_high_width", run, HALF);
                    since_fall = 0;
                    fall_bit = fall_bit + 3'd1;
                    if (fall_bit == 3'd0) cur_out = last_mosi_byte;
                end
                run = 1;
            end else begin
                run++;
            end
            if (ss && !ss_q) begin
                chk("last_fall_to_ss_rise", since_fall, HOLD);
                chk("burst_len_pending", exp_len_q.size() > 0, 1);
                if (exp_len_q.size() > 0) chk("sck_rises_per_burst", burst_rises, 8 * (exp_len_q.pop_front() + 1));
                since_ss_rise = 0;
            end
            if (rx_valid) begin
                rx_log.push_back(rx_data);
                chk("rx_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("rx_data", rx_data, exp_q.pop_front());
            end
            if (done) done_cnt++;
            sck_q = sck; ss_q = ss;
        end
    end

    // ---------------- driver tasks (entered and left on a negedge) ----------------
    task automatic start_cmd(input int len);
        int t = 0;
        cmd_len = LEN_W'(len);
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_accept_timeout", t < 400, 1);
        exp_len_q.push_back(len);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall);
        int t = 0;
        while (!tx_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("tx_ready_timeout", t < 400, 1);
        for (int i = 0; i < stall; i++) begin
            chk("stall_sck_low", sck, 1'b0);
            chk("stall_ss_low", ss, 1'b0);
            chk("stall_tx_ready", tx_ready, 1'b1);
            @(negedge clk);
        end
        tx_data = b;
        tx_valid = 1'b1;
        exp_tx_q.push_back(b);
        exp_q.push_back(loop_mode ? b : drv_prev);
        drv_prev = b;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic wait_done();
        int start = done_cnt;
        int t = 0;
        while (done_cnt == start && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("done_timeout", t < 3000, 1);
    endtask

    task automatic run_burst(input int stall_idx, input int stall_len, input bit poke);
        start_cmd(burst_q.size() - 1);
        for (int i = 0; i < burst_q.size(); i++) begin
            send_byte(burst_q[i], (i == stall_idx) ? stall_len : 0);
            if (poke && i == 0) begin
                chk("cmd_ready_low_while_busy", cmd_ready, 1'b0);
                cmd_len = 4'd7;
                cmd_valid = 1'b1;
                @(negedge clk);
                cmd_valid = 1'b0;
            end
        end
        wait_done();
    endtask

    // ---------------- stimulus ----------------
    int r0, d0;

    initial begin
        // 1. reset state
        repeat (10) @(negedge clk);
        chk("rst_ss", ss, 1'b1);
        chk("rst_sck", sck, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_tx_ready", tx_ready, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_state_dbg", state_dbg, 3'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 2. single byte, loopback
        loop_mode = 1'b1;
        rx_log.delete(); mosi_log.delete();
        r0 = total_rises; d0 = done_cnt;
        burst_q = '{8'hAA};
        run_burst(-1, 0, 1'b0);
        repeat (4) @(negedge clk);
        chk("s2_rises", total_rises - r0, 8);
        chk("s2_done_pulses", done_cnt - d0, 1);
        chk("s2_mosi_count", mosi_log.size(), 1);
        if (mosi_log.size() > 0) chk("s2_mosi_byte", mosi_log[0], 8'hAA);
        chk("s2_rx_count", rx_log.size(), 1);
        if (rx_log.size() > 0) chk("s2_rx_byte", rx_log[0], 8'hAA);
        chk("s2_rx_data_held", rx_data, 8'hAA);

        // 1b. reset in the middle of a byte
        rx_log.delete();
        burst_q = '{8'h3C};
        start_cmd(0);
        send_byte(8'h3C, 0);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ss", ss, 1'b1);
        chk("midrst_sck", sck, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_cmd_ready", cmd_ready, 1'b1);
        chk("midrst_rx_valid", rx_valid, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_mosi", mosi, 1'b0);
        chk("midrst_rx_data", rx_data, 8'h00);
        exp_q.delete(); exp_tx_q.delete(); exp_len_q.delete();
        drv_prev = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("midrst_no_rx", rx_log.size(), 0);

        // 3. burst against the previous-byte slave
        loop_mode = 1'b0;
        rx_log.delete();
        r0 = total_rises;
        burst_q = '{8'hAA, 8'hFF, 8'h00, 8'hAA};
        run_burst(-1, 0, 1'b0);
        repeat (4) @(negedge clk);
        chk("s3_rises", total_rises - r0, 32);
        chk("s3_rx_count", rx_log.size(), 4);
        if (rx_log.size() == 4) begin
            chk("s3_rx0", rx_log[0], 8'h00);
            chk("s3_rx1", rx_log[1], 8'hAA);
            chk("s3_rx2", rx_log[2], 8'hFF);
            chk("s3_rx3", rx_log[3], 8'h00);
        end

        // 4. tx underrun before byte 2
        loop_mode = 1'b1;
        rx_log.delete();
        r0 = total_rises;
        burst_q = '{8'h5A, 8'hC3};
        run_burst(1, 20, 1'b0);
        repeat (4) @(negedge clk);
        chk("s4_rises", total_rises - r0, 16);
        chk("s4_rx_count", rx_log.size(), 2);
        if (rx_log.size() == 2) begin
            chk("s4_rx0", rx_log[0], 8'h5A);
            chk("s4_rx1", rx_log[1], 8'hC3);
        end

        // 5. command while busy, then a back-to-back command
        r0 = total_rises;
        burst_q = '{8'h11, 8'h22};
        run_burst(-1, 0, 1'b1);
        burst_q = '{8'h33};
        run_burst(-1, 0, 1'b0);
        repeat (20) @(negedge clk);
        chk("s5_rises", total_rises - r0, 24);
        chk("s5_idle_ss", ss, 1'b1);
        chk("s5_idle_busy", busy, 1'b0);

        // randomized bursts
        for (int n = 0; n < 8; n++) begin
            int nb;
            int sidx;
            loop_mode = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 4);
            burst_q.delete();
            for (int i = 0; i < nb; i++) burst_q.push_back(8'($urandom));
            sidx = $urandom_range(0, 1) ? $urandom_range(0, nb - 1) : -1;
            run_burst(sidx, $urandom_range(1, 12), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        // boundary: cmd_len all ones -> 16 bytes
        loop_mode = 1'b0;
        r0 = total_rises;
        burst_q.delete();
        for (int i = 0; i < 16; i++) burst_q.push_back(8'($urandom));
        run_burst(-1, 0, 1'b0);
        repeat (4) @(negedge clk);
        chk("max_len_rises", total_rises - r0, 128);

        repeat (10) @(negedge clk);
        chk("end_exp_rx_empty", exp_q.size(), 0);
        chk("end_exp_tx_empty", exp_tx_q.size(), 0);
        chk("end_exp_len_empty", exp_len_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
